// File: rtl/bp_sacc_he_dma_reader_pkg.sv
// ---------------------------------------------------------------------------
// bp_sacc_he_dma_reader_pkg
// Shared accelerator package: DMA reader state encoding, transfer word size
// and the accelerator CSR index map used by the host-facing register block.
// ---------------------------------------------------------------------------
package bp_sacc_he_dma_reader_pkg;

  // DMA reader control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

  // Every read moves one 32-bit word.
  localparam int unsigned word_bytes_c = 4;

  // Accelerator CSR indices.
  localparam int unsigned csr_src_addr_idx_c = 0;
  localparam int unsigned csr_length_idx_c   = 1;
  localparam int unsigned csr_spm_base_idx_c = 2;
  localparam int unsigned csr_start_idx_c    = 3;
  localparam int unsigned csr_status_idx_c   = 4;

endpackage

// File: rtl/bsg_counter_up_down.sv
// ---------------------------------------------------------------------------
// bsg_counter_up_down
// Up/down counter used as the outstanding-read credit counter.
//   clk_i    : clock, rising edge
//   reset_i  : asynchronous active-low reset, clears the count
//   up_i     : increment by one this cycle
//   down_i   : decrement by one this cycle (nets against up_i)
//   count_o  : current count
// The owner guarantees the count stays within 0..max_val_p.
// ---------------------------------------------------------------------------
module bsg_counter_up_down #(
  parameter int max_val_p = 4,
  parameter int width_p   = $clog2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q;
  logic [width_p-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (up_i && !down_i) begin
      count_d = count_q + width_p'(1);
    end else if (down_i && !up_i) begin
      count_d = count_q - width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_sacc_he_dma_reader.sv
// ---------------------------------------------------------------------------
// bp_sacc_he_dma_reader
// Copies length_i consecutive 32-bit words from memory (starting at byte
// address src_addr_i) into the scratchpad starting at word spm_base_i.
// Reads are pipelined with up to max_outstanding_p commands in flight;
// responses return in order and are written to the SPM one cycle later.
//   clk_i / reset_i          : clock, asynchronous active-low reset
//   start_i, src_addr_i,
//   length_i, spm_base_i     : transfer request, sampled only in IDLE
//   busy_o, done_o           : transfer active / sticky completion
//   mem_cmd_*                : 4-byte uncached read command (valid/ready)
//   mem_resp_*               : read response (always ready)
//   spm_w_v_o, spm_addr_o,
//   spm_data_o               : registered scratchpad write port
// ---------------------------------------------------------------------------
module bp_sacc_he_dma_reader
  import bp_sacc_he_dma_reader_pkg::*;
#(
  parameter int paddr_width_p     = 40,
  parameter int spm_els_p         = 4096,
  parameter int max_outstanding_p = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [paddr_width_p-1:0]     src_addr_i,
  input  logic [15:0]                  length_i,
  input  logic [$clog2(spm_els_p)-1:0] spm_base_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         mem_cmd_v_o,
  output logic [paddr_width_p-1:0]     mem_cmd_addr_o,
  input  logic                         mem_cmd_ready_i,
  input  logic                         mem_resp_v_i,
  input  logic [31:0]                  mem_resp_data_i,
  output logic                         mem_resp_ready_o,
  output logic                         spm_w_v_o,
  output logic [$clog2(spm_els_p)-1:0] spm_addr_o,
  output logic [31:0]                  spm_data_o
);

  localparam int spm_aw_lp     = $clog2(spm_els_p);
  localparam int out_w_lp      = $clog2(max_outstanding_p + 1);
  localparam int word_shift_lp = $clog2(word_bytes_c);
  localparam logic [out_w_lp-1:0]  max_out_lp  = out_w_lp'(max_outstanding_p);
  localparam logic [spm_aw_lp-1:0] spm_last_lp = spm_aw_lp'(spm_els_p - 1);

  dma_state_e                 state_q, state_d;
  logic [paddr_width_p-1:0]   src_q, src_d;
  logic [15:0]                len_q, len_d;
  logic [15:0]                issue_cnt_q, issue_cnt_d;
  logic [15:0]                recv_cnt_q, recv_cnt_d;
  // Next SPM index to write; kept as a wrapping pointer so non-power-of-two
  // SPM depths wrap correctly without a modulo.
  logic [spm_aw_lp-1:0]       spm_ptr_q, spm_ptr_d;
  logic                       done_q, done_d;
  logic                       spm_w_v_q, spm_w_v_d;
  logic [spm_aw_lp-1:0]       spm_addr_q, spm_addr_d;
  logic [31:0]                spm_data_q, spm_data_d;

  logic [out_w_lp-1:0]        outstanding;
  logic                       cmd_fire;
  logic                       resp_fire;
  logic                       active;

  assign active = (state_q == ISSUE) || (state_q == DRAIN);

  // Command valid depends only on registered state, so once raised it holds
  // (with a stable address) until the handshake: nothing but an accepted
  // command can advance issue_cnt_q, and responses only free credits.
  assign mem_cmd_v_o    = (state_q == ISSUE) && (outstanding < max_out_lp)
                          && (issue_cnt_q < len_q);
  assign mem_cmd_addr_o = src_q + (paddr_width_p'(issue_cnt_q) << word_shift_lp);
  assign cmd_fire       = mem_cmd_v_o && mem_cmd_ready_i;

  // A response with no credit outstanding cannot belong to this transfer;
  // refusing it keeps the credit counter from underflowing.
  assign resp_fire = mem_resp_v_i && active && (outstanding != '0);

  bsg_counter_up_down #(
    .max_val_p (max_outstanding_p),
    .width_p   (out_w_lp)
  ) u_credit (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (cmd_fire),
    .down_i  (resp_fire),
    .count_o (outstanding)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    spm_ptr_d   = spm_ptr_q;
    done_d      = done_q;
    spm_w_v_d   = resp_fire;
    spm_addr_d  = spm_ptr_q;
    spm_data_d  = mem_resp_data_i;

    if (cmd_fire) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    if (resp_fire) begin
      recv_cnt_d = recv_cnt_q + 16'd1;
      spm_ptr_d  = (spm_ptr_q == spm_last_lp) ? '0 : spm_ptr_q + spm_aw_lp'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (length_i != 16'd0) begin
            src_d       = src_addr_i;
            len_d       = length_i;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            spm_ptr_d   = spm_base_i;
            done_d      = 1'b0;
            state_d     = ISSUE;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        if (cmd_fire && (issue_cnt_d == len_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last SPM write is registered on this same edge.
        if (recv_cnt_d == len_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      src_q       <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      spm_ptr_q   <= '0;
      done_q      <= 1'b0;
      spm_w_v_q   <= 1'b0;
      spm_addr_q  <= '0;
      spm_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      spm_ptr_q   <= spm_ptr_d;
      done_q      <= done_d;
      spm_w_v_q   <= spm_w_v_d;
      spm_addr_q  <= spm_addr_d;
      spm_data_q  <= spm_data_d;
    end
  end

  assign busy_o           = active;
  assign done_o           = done_q;
  assign mem_resp_ready_o = 1'b1;
  assign spm_w_v_o        = spm_w_v_q;
  assign spm_addr_o       = spm_addr_q;
  assign spm_data_o       = spm_data_q;

endmodule

// File: tb/tb_bp_sacc_he_dma_reader.sv
// ---------------------------------------------------------------------------
// tb_bp_sacc_he_dma_reader
// Directed and randomized transfers against an in-order memory responder.
// Expected command addresses, SPM indices and data come from the transfer
// rules: address src+4*i, index (base+i) mod depth, data = memory contents.
// ---------------------------------------------------------------------------
module tb_bp_sacc_he_dma_reader;

  localparam int SPM_ELS = 4096;
  localparam int MAX_OUT = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [39:0] src_addr_i;
  logic [15:0] length_i;
  logic [11:0] spm_base_i;
  logic        busy_o, done_o, mem_cmd_v_o;
  logic [39:0] mem_cmd_addr_o;
  logic        mem_cmd_ready_i = 1'b0;
  logic        mem_resp_v_i = 1'b0;
  logic [31:0] mem_resp_data_i = 32'h0;
  logic        mem_resp_ready_o, spm_w_v_o;
  logic [11:0] spm_addr_o;
  logic [31:0] spm_data_o;

  int checks = 0;
  int errors = 0;

  // Responder controls (written by the stimulus, read by the responder).
  bit hold_resp = 1'b0;
  bit ready_low = 1'b0;
  bit ready_rand = 1'b0;
  bit lat_rand = 1'b0;
  logic [31:0] salt = 32'h1234_5678;

  int          cyc = 0;
  int          q_due[$];
  logic [31:0] q_data[$];
  logic [39:0] cmd_log[$];
  logic [11:0] spm_addr_log[$];
  logic [31:0] spm_data_log[$];

  bp_sacc_he_dma_reader dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .start_i         (start_i),
    .src_addr_i      (src_addr_i),
    .length_i        (length_i),
    .spm_base_i      (spm_base_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .mem_cmd_v_o     (mem_cmd_v_o),
    .mem_cmd_addr_o  (mem_cmd_addr_o),
    .mem_cmd_ready_i (mem_cmd_ready_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_data_i (mem_resp_data_i),
    .mem_resp_ready_o(mem_resp_ready_o),
    .spm_w_v_o       (spm_w_v_o),
    .spm_addr_o      (spm_addr_o),
    .spm_data_o      (spm_data_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [39:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ {a[39:32], 24'h0} ^ salt;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // In-order memory: drives inputs on the falling edge, logs handshakes that
  // will complete on the next rising edge, and logs SPM writes.
  always @(negedge clk_i) begin
    int pending;
    cyc++;
    pending = q_due.size();
    if (!hold_resp && q_due.size() > 0 && q_due[0] <= cyc) begin
      mem_resp_v_i    = 1'b1;
      mem_resp_data_i = q_data.pop_front();
      void'(q_due.pop_front());
    end else begin
      mem_resp_v_i    = 1'b0;
      mem_resp_data_i = $urandom();
    end
    if (ready_low)       mem_cmd_ready_i = 1'b0;
    else if (ready_rand) mem_cmd_ready_i = ($urandom_range(0, 99) < 70);
    else                 mem_cmd_ready_i = 1'b1;
    if (mem_cmd_v_o && mem_cmd_ready_i) begin
      check("outstanding_limit", 64'(pending < MAX_OUT), 64'd1);
      cmd_log.push_back(mem_cmd_addr_o);
      q_data.push_back(mem_word(mem_cmd_addr_o));
      q_due.push_back(cyc + (lat_rand ? $urandom_range(1, 4) : 2));
    end
    if (spm_w_v_o) begin
      spm_addr_log.push_back(spm_addr_o);
      spm_data_log.push_back(spm_data_o);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic clear_logs();
    cmd_log.delete();
    spm_addr_log.delete();
    spm_data_log.delete();
  endtask

  // Start, then hold start_i one more cycle with a junk configuration that
  // must be ignored because the block is no longer idle.
  task automatic start_xfer(input logic [39:0] src, input logic [15:0] len, input logic [11:0] base);
    clear_logs();
    src_addr_i = src;
    length_i   = len;
    spm_base_i = base;
    start_i    = 1'b1;
    tick(1);
    src_addr_i = {8'($urandom()), 32'($urandom() & 32'hFFFF_FFFC)};
    length_i   = 16'($urandom_range(1, 50));
    spm_base_i = 12'($urandom());
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_o && n < 3000) begin
      tick(1);
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_o), 64'd1);
    tick(3);
  endtask

  task automatic verify(input string tag, input logic [39:0] src, input int len, input logic [11:0] base);
    logic [39:0] ea;
    logic [11:0] ei;
    check({tag, "_ncmd"}, 64'(cmd_log.size()), 64'(len));
    check({tag, "_nspm"}, 64'(spm_addr_log.size()), 64'(len));
    for (int i = 0; i < len; i++) begin
      ea = src + 40'(4 * i);
      ei = 12'((int'(base) + i) % SPM_ELS);
      if (i < cmd_log.size())
        check($sformatf("%s_cmd%0d", tag, i), 64'(cmd_log[i]), 64'(ea));
      if (i < spm_addr_log.size()) begin
        check($sformatf("%s_idx%0d", tag, i), 64'(spm_addr_log[i]), 64'(ei));
        check($sformatf("%s_dat%0d", tag, i), 64'(spm_data_log[i]), 64'(mem_word(ea)));
      end
    end
    check({tag, "_busy_end"}, 64'(busy_o), 64'd0);
    check({tag, "_done_end"}, 64'(done_o), 64'd1);
  endtask

  task automatic run_xfer(input string tag, input logic [39:0] src, input logic [15:0] len, input logic [11:0] base);
    start_xfer(src, len, base);
    check({tag, "_busy_start"}, 64'(busy_o), 64'd1);
    check({tag, "_done_cleared"}, 64'(done_o), 64'd0);
    wait_done(tag);
    verify(tag, src, int'(len), base);
  endtask

  initial begin
    int          hi;
    logic [39:0] rs;
    logic [15:0] rl;
    logic [11:0] rb;

    salt       = $urandom();
    reset_i    = 1'b0;
    start_i    = 1'b0;
    src_addr_i = '0;
    length_i   = '0;
    spm_base_i = '0;
    tick(3);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    check("rst_spm_w_v", 64'(spm_w_v_o), 64'd0);
    check("resp_ready", 64'(mem_resp_ready_o), 64'd1);
    reset_i = 1'b1;
    tick(2);

    // Basic 3-word transfer, always-ready memory, 2-cycle latency.
    run_xfer("basic", 40'h00_8000_1000, 16'd3, 12'h010);

    // Zero length: done within 2 cycles, nothing issued or written.
    start_xfer(40'h00_0000_4000, 16'd0, 12'h020);
    check("len0_done", 64'(done_o), 64'd1);
    check("len0_busy", 64'(busy_o), 64'd0);
    tick(6);
    check("len0_ncmd", 64'(cmd_log.size()), 64'd0);
    check("len0_nspm", 64'(spm_addr_log.size()), 64'd0);

    // Back-pressure: command held stable while ready is low for 5 cycles.
    ready_low = 1'b1;
    start_xfer(40'h00_0000_2000, 16'd3, 12'h100);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_cmd_v%0d", i), 64'(mem_cmd_v_o), 64'd1);
      check($sformatf("bp_addr%0d", i), 64'(mem_cmd_addr_o), 64'h00_0000_2000);
      tick(1);
    end
    ready_low = 1'b0;
    wait_done("bp");
    verify("bp", 40'h00_0000_2000, 3, 12'h100);

    // Credit limit: with responses withheld only 4 of 8 commands go out.
    hold_resp = 1'b1;
    start_xfer(40'h00_0001_0000, 16'd8, 12'h200);
    tick(10);
    hi = 0;
    for (int i = 0; i < 15; i++) begin
      if (mem_cmd_v_o) hi++;
      tick(1);
    end
    check("credit_ncmd_held", 64'(cmd_log.size()), 64'd4);
    check("credit_cmd_v_low_cycles", 64'(hi), 64'd0);
    check("credit_busy_held", 64'(busy_o), 64'd1);
    hold_resp = 1'b0;
    wait_done("credit");
    verify("credit", 40'h00_0001_0000, 8, 12'h200);

    // SPM index wrap at the top of the scratchpad.
    run_xfer("spmwrap", 40'h00_0000_8000, 16'd4, 12'hFFE);

    // Randomized transfers with random ready and latency.
    ready_rand = 1'b1;
    lat_rand   = 1'b1;
    for (int t = 0; t < 8; t++) begin
      rs = (t == 0) ? 40'hFF_FFFF_FFF8 : {8'($urandom()), 32'($urandom() & 32'hFFFF_FFFC)};
      rl = (t == 0) ? 16'd5 : 16'($urandom_range(1, 24));
      rb = 12'($urandom());
      run_xfer($sformatf("rnd%0d", t), rs, rl, rb);
    end
    ready_rand = 1'b0;
    lat_rand   = 1'b0;

    // Reset in DRAIN: outputs clear at once, stray responses are dropped.
    hold_resp = 1'b1;
    start_xfer(40'h00_0002_0000, 16'd4, 12'h300);
    tick(10);
    check("drain_busy", 64'(busy_o), 64'd1);
    check("drain_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    check("drain_ncmd", 64'(cmd_log.size()), 64'd4);
    #3;
    reset_i = 1'b0;
    #1;
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_done", 64'(done_o), 64'd0);
    check("arst_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    check("arst_spm_w_v", 64'(spm_w_v_o), 64'd0);
    clear_logs();
    tick(2);
    reset_i   = 1'b1;
    hold_resp = 1'b0;
    tick(12);
    check("stray_nspm", 64'(spm_addr_log.size()), 64'd0);
    check("stray_busy", 64'(busy_o), 64'd0);
    check("stray_done", 64'(done_o), 64'd0);
    run_xfer("post_rst", 40'h00_0003_0000, 16'd6, 12'h040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_sacc_he_dma_reader.md
BP_SACC_HE_DMA_READER -- requirements
Module: bp_sacc_he_dma_reader

Interface
REQ-001 SHALL have parameter paddr_width_p, default 40, meaning the physical address width.
REQ-002 SHALL have parameter spm_els_p, default 4096, meaning the SPM depth in 32-bit words.
REQ-003 SHALL have parameter max_outstanding_p, default 4, meaning the maximum number of read commands in flight.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state is on the rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start_i, input, 1 bit: a one-cycle request to begin a transfer.
REQ-007 SHALL have port src_addr_i, input, paddr_width_p bits: byte address of the first word, 4-byte aligned.
REQ-008 SHALL have port length_i, input, 16 bits: number of 32-bit words to transfer.
REQ-009 SHALL have port spm_base_i, input, clog2(spm_els_p) bits: first SPM word index to write.
REQ-010 SHALL have port busy_o, output, 1 bit: high while a transfer is active.
REQ-011 SHALL have port done_o, output, 1 bit: sticky completion flag.
REQ-012 SHALL have port mem_cmd_v_o, output, 1 bit: read command valid.
REQ-013 SHALL have port mem_cmd_addr_o, output, paddr_width_p bits: read byte address, size is always 4 bytes, uncached read.
REQ-014 SHALL have port mem_cmd_ready_i, input, 1 bit: the command is accepted when valid and ready are both high.
REQ-015 SHALL have port mem_resp_v_i, input, 1 bit: read response valid.
REQ-016 SHALL have port mem_resp_data_i, input, 32 bits: read response data.
REQ-017 SHALL have port mem_resp_ready_o, output, 1 bit: tied to 1.
REQ-018 SHALL have port spm_w_v_o, output, 1 bit: SPM write strobe.
REQ-019 SHALL have port spm_addr_o, output, clog2(spm_els_p) bits: SPM write index.
REQ-020 SHALL have port spm_data_o, output, 32 bits: SPM write data.

Function
REQ-021 SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-022 In IDLE, start_i with length_i>0 SHALL latch src_addr_i, length_i and spm_base_i, clear done_o, and go to ISSUE the next cycle.
REQ-023 In IDLE, start_i with length_i==0 SHALL go to DONE without issuing any command.
REQ-024 In ISSUE, mem_cmd_v_o SHALL be high whenever issued-minus-received < max_outstanding_p and issued < length.
REQ-025 mem_cmd_addr_o SHALL equal src_addr + 4*issue_count, computed in paddr_width_p bits and wrapping modulo 2^paddr_width_p.
REQ-026 Once mem_cmd_v_o is asserted, it and mem_cmd_addr_o SHALL hold stable until accepted.
REQ-027 After the final command is accepted, the block SHALL go to DRAIN.
REQ-028 Each mem_resp_v_i cycle SHALL produce, registered, spm_w_v_o=1 one cycle later, with spm_data_o equal to the response data and spm_addr_o equal to spm_base + recv_count, wrapping modulo spm_els_p.
REQ-029 Responses SHALL be accepted in ISSUE and DRAIN, including in the same cycle as a command acceptance; the outstanding count nets both events.
REQ-030 mem_resp_v_i in IDLE or DONE SHALL be dropped, with no SPM write.
REQ-031 In DRAIN, the cycle recv_count reaches length SHALL move the block to DONE after the final SPM write has been issued.
REQ-032 DONE SHALL set done_o, which stays set until the next accepted start_i, and SHALL return to IDLE the next cycle.
REQ-033 busy_o SHALL be high in ISSUE and DRAIN only.
REQ-034 start_i while busy_o is high SHALL be ignored, and the latched configuration SHALL be unchanged.
REQ-035 Counters SHALL be 16 bits and the outstanding counter SHALL be clog2(max_outstanding_p+1) bits; neither SHALL overflow by construction.

Reset
REQ-036 Asserting reset_i low SHALL immediately force the state to IDLE, clear all counters, and drive busy_o, done_o, mem_cmd_v_o and spm_w_v_o to 0, including mid-transfer.
REQ-037 After reset, responses still in flight SHALL be dropped per REQ-030.

Structure
REQ-038 The state enum and the 4-byte word-size constant SHALL live in the shared accelerator package, alongside the accelerator CSR index constants.
REQ-039 The outstanding-credit counter SHALL be a single sub-module, bsg_counter_up_down, instantiated once.

Verification
REQ-040 Bench SHALL check: start, src 0x80001000, length 3, base 0x10, with an always-ready memory of 2-cycle latency -> commands at 0x80001000, 0x80001004 and 0x80001008; SPM writes at indices 0x10, 0x11 and 0x12 with the matching data; done_o set.
REQ-041 Bench SHALL check: length 8 with responses withheld -> exactly 4 commands issued, then mem_cmd_v_o stays low until the first response arrives.
REQ-042 Bench SHALL check: length 0 -> done_o set within 2 cycles, with no command and no SPM write.
REQ-043 Bench SHALL check: mem_cmd_ready_i low for 5 cycles -> the command address stays stable, and no command is duplicated or skipped.
REQ-044 Bench SHALL check: base 0xFFE, length 4 -> SPM indices 0xFFE, 0xFFF, 0x000 and 0x001.
REQ-045 Bench SHALL check: reset_i pulsed low during DRAIN -> all outputs are 0 asynchronously, a stray response causes no SPM write, and a new start completes normally.
